// File: rtl/fft_pkg.sv
// Shared FFT datapath widths and the derived multiplier widths.
package fft_pkg;

  localparam int FFT_DATA_W = 16;
  localparam int FFT_COEF_W = 16;

  // Full-precision widths for the default operand sizes
  localparam int FFT_PROD_W = FFT_DATA_W + FFT_COEF_W + 1;
  localparam int FFT_SUM_W  = FFT_DATA_W + FFT_COEF_W + 2;

  // The same formulas for any parameterised instance.
  // The extra product bit holds the negated -2^(COEF_W-1) coefficient.
  // The extra sum bit absorbs the add/subtract carry.
  function automatic int prod_w(input int data_w, input int coef_w);
    return data_w + coef_w + 1;
  endfunction

  function automatic int sum_w(input int data_w, input int coef_w);
    return data_w + coef_w + 2;
  endfunction

endpackage

// File: rtl/cmult_round_sat.sv
// Combinational output stage.
// Applies an optional half-up round, an arithmetic right shift,
// and then either a clamp or a wrap to OUT_W bits.
module cmult_round_sat #(
  parameter int IN_W     = 34,
  parameter int OUT_W    = 16,
  parameter int FRAC_W   = 15,
  parameter bit ROUND_EN = 1'b1,
  parameter bit SAT_EN   = 1'b1
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout,
  output logic                    sat
);

  // One guard bit so the rounding add can never wrap
  localparam logic signed [IN_W:0] HALF  = ROUND_EN ? ((IN_W+1)'(1) << (FRAC_W-1)) : '0;
  localparam logic signed [IN_W:0] MAX_V = {{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W:0] MIN_V = {{(IN_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [IN_W:0] rounded;
  logic signed [IN_W:0] shifted;

  assign rounded = {din[IN_W-1], din} + HALF;
  assign shifted = rounded >>> FRAC_W;

  // Clamp to the OUT_W range when saturation is enabled, otherwise keep the low bits
  always_comb begin
    dout = shifted[OUT_W-1:0];
    sat  = 1'b0;
    if (SAT_EN) begin
      if (shifted > MAX_V) begin
        dout = MAX_V[OUT_W-1:0];
        sat  = 1'b1;
      end else if (shifted < MIN_V) begin
        dout = MIN_V[OUT_W-1:0];
        sat  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cmult_pipe.sv
// Four-stage pipelined complex multiplier computing A*B or A*conj(B).
// Precision is kept in full until a single round/saturate step at the output.
// A single global enable stalls every stage together when the output is blocked.
module cmult_pipe
  import fft_pkg::*;
#(
  parameter int DATA_W   = FFT_DATA_W,
  parameter int COEF_W   = FFT_COEF_W,
  parameter int OUT_W    = 16,
  parameter int FRAC_W   = COEF_W - 1,
  parameter bit ROUND_EN = 1'b1,
  parameter bit SAT_EN   = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_a_re,
  input  logic signed [DATA_W-1:0] in_a_im,
  input  logic signed [COEF_W-1:0] in_b_re,
  input  logic signed [COEF_W-1:0] in_b_im,
  input  logic                     in_conj,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OUT_W-1:0]  out_re,
  output logic signed [OUT_W-1:0]  out_im,
  output logic                     out_sat
);

  localparam int PROD_W = prod_w(DATA_W, COEF_W);
  localparam int SUM_W  = sum_w(DATA_W, COEF_W);

  logic en;
  logic v1, v2, v3;

  logic signed [DATA_W-1:0] a_re1, a_im1;
  logic signed [COEF_W-1:0] b_re1;
  logic signed [COEF_W:0]   b_im1, b_im_ext, b_im_eff;

  logic signed [PROD_W-1:0] a_re_x, a_im_x, b_re_x, b_im_x;
  logic signed [PROD_W-1:0] rr2, ii2, ri2, ir2;
  logic signed [SUM_W-1:0]  sum_re3, sum_im3;

  logic signed [OUT_W-1:0] rs_re, rs_im;
  logic                    sat_re, sat_im;

  assign en       = out_ready || !out_valid;
  assign in_ready = en;

  // Negate one bit wider so that negating the most negative coefficient stays exact
  assign b_im_ext = {in_b_im[COEF_W-1], in_b_im};
  assign b_im_eff = in_conj ? -b_im_ext : b_im_ext;

  assign a_re_x = PROD_W'(a_re1);
  assign a_im_x = PROD_W'(a_im1);
  assign b_re_x = PROD_W'(b_re1);
  assign b_im_x = PROD_W'(b_im1);

  cmult_round_sat #(
    .IN_W(SUM_W), .OUT_W(OUT_W), .FRAC_W(FRAC_W), .ROUND_EN(ROUND_EN), .SAT_EN(SAT_EN)
  ) u_rs_re (
    .din(sum_re3), .dout(rs_re), .sat(sat_re)
  );

  cmult_round_sat #(
    .IN_W(SUM_W), .OUT_W(OUT_W), .FRAC_W(FRAC_W), .ROUND_EN(ROUND_EN), .SAT_EN(SAT_EN)
  ) u_rs_im (
    .din(sum_im3), .dout(rs_im), .sat(sat_im)
  );

  // Valid chain. Bubbles advance like beats, so ordering and latency stay fixed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      v3        <= 1'b0;
      out_valid <= 1'b0;
    end else if (en) begin
      v1        <= in_valid;
      v2        <= v1;
      v3        <= v2;
      out_valid <= v3;
    end
  end

  // Data path S1..S3. Contents of invalid stages are don't-care.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_re1   <= '0;
      a_im1   <= '0;
      b_re1   <= '0;
      b_im1   <= '0;
      rr2     <= '0;
      ii2     <= '0;
      ri2     <= '0;
      ir2     <= '0;
      sum_re3 <= '0;
      sum_im3 <= '0;
    end else if (en) begin
      a_re1   <= in_a_re;
      a_im1   <= in_a_im;
      b_re1   <= in_b_re;
      b_im1   <= b_im_eff;
      rr2     <= a_re_x * b_re_x;
      ii2     <= a_im_x * b_im_x;
      ri2     <= a_re_x * b_im_x;
      ir2     <= a_im_x * b_re_x;
      sum_re3 <= SUM_W'(rr2) - SUM_W'(ii2);
      sum_im3 <= SUM_W'(ri2) + SUM_W'(ir2);
    end
  end

  // S4 output register. It holds steady while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_re  <= '0;
      out_im  <= '0;
      out_sat <= 1'b0;
    end else if (en) begin
      out_re  <= rs_re;
      out_im  <= rs_im;
      out_sat <= sat_re | sat_im;
    end
  end

endmodule
